// File: rtl/arbitro_mux3.sv
// Round-robin arbiter/sequencer for a 3-input mux with valid/ready handoff and per-grant watchdog.
// Macro ARBITRO_MUX3_RR_EN selects round-robin; undefined gives fixed priority 0 > 1 > 2.
module arbitro_mux3 #(
    parameter int unsigned LIMITE = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] Pedido,
    input  logic       Pronto,
    output logic [1:0] Controle,
    output logic [2:0] Concessao,
    output logic       Valido,
    output logic       Aceito,
    output logic       Estouro
);
    localparam int CW = $clog2(LIMITE + 1);

    typedef enum logic {OCIOSO, CONCEDIDO} estado_t;

    estado_t         r_estado;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_controle;
    logic [2:0]      r_concessao;
    logic            r_valido;
    logic            r_aceito;
    logic            r_estouro;
    logic [1:0]      w_inicio;
    logic [1:0]      w_venc;

    // First requester found scanning ini, ini+1, ini+2 (mod 3).
    function automatic logic [1:0] escolhe(input logic [2:0] req, input logic [1:0] ini);
        logic [2:0] s;
        logic [1:0] idx;
        escolhe = ini;
        for (int k = 2; k >= 0; k--) begin
            s   = {1'b0, ini} + 3'(k);
            idx = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
            if (req[idx]) escolhe = idx;
        end
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] x);
        inc3 = (x == 2'd2) ? 2'd0 : 2'(x + 2'd1);
    endfunction

`ifdef ARBITRO_MUX3_RR_EN
    logic [1:0] r_ultimo;
    assign w_inicio = (r_estado == OCIOSO) ? inc3(r_ultimo) : inc3(r_controle);
`else
    assign w_inicio = 2'd0;
`endif

    assign w_venc = escolhe(Pedido, w_inicio);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_estado    <= OCIOSO;
            r_cnt       <= '0;
            r_controle  <= 2'd0;
            r_concessao <= 3'b000;
            r_valido    <= 1'b0;
            r_aceito    <= 1'b0;
            r_estouro   <= 1'b0;
`ifdef ARBITRO_MUX3_RR_EN
            r_ultimo    <= 2'd2;
`endif
        end else begin
            r_aceito  <= 1'b0;
            r_estouro <= 1'b0;
            if (r_estado == OCIOSO) begin
                if (|Pedido) begin
                    r_estado    <= CONCEDIDO;
                    r_controle  <= w_venc;
                    r_concessao <= 3'b001 << w_venc;
                    r_valido    <= 1'b1;
                    r_cnt       <= '0;
                end
            end else if (Pronto) begin
                // Transfer done; chain straight into the next grant if anyone waits.
                r_aceito <= 1'b1;
`ifdef ARBITRO_MUX3_RR_EN
                r_ultimo <= r_controle;
`endif
                if (|Pedido) begin
                    r_controle  <= w_venc;
                    r_concessao <= 3'b001 << w_venc;
                    r_cnt       <= '0;
                end else begin
                    r_estado    <= OCIOSO;
                    r_concessao <= 3'b000;
                    r_valido    <= 1'b0;
                end
            end else if ((Pedido & r_concessao) == 3'b000) begin
                r_estado    <= OCIOSO;
                r_concessao <= 3'b000;
                r_valido    <= 1'b0;
            end else if (r_cnt == CW'(LIMITE - 1)) begin
                r_estouro   <= 1'b1;
`ifdef ARBITRO_MUX3_RR_EN
                r_ultimo    <= r_controle;
`endif
                r_estado    <= OCIOSO;
                r_concessao <= 3'b000;
                r_valido    <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign Controle  = r_controle;
    assign Concessao = r_concessao;
    assign Valido    = r_valido;
    assign Aceito    = r_aceito;
    assign Estouro   = r_estouro;
endmodule

// File: tb/tb_arbitro_mux3.sv
// Self-checking bench for arbitro_mux3: directed literal cases plus randomized traffic against a transaction model.
module tb_arbitro_mux3;
    localparam int LIM = 3;
`ifdef ARBITRO_MUX3_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Pedido = 3'b000;
    logic       Pronto = 1'b0;
    logic [1:0] Controle;
    logic [2:0] Concessao;
    logic       Valido, Aceito, Estouro;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    arbitro_mux3 #(.LIMITE(LIM)) dut (
        .Clock(Clock), .Reset(Reset), .Pedido(Pedido), .Pronto(Pronto),
        .Controle(Controle), .Concessao(Concessao), .Valido(Valido),
        .Aceito(Aceito), .Estouro(Estouro)
    );

    // Transaction model: who owns the path (-1 = nobody), how long it has waited, last served.
    int         m_owner  = -1;
    int         m_wait   = 0;
    int         m_ultimo = 2;
    logic [1:0] m_ctrl   = 2'd0;
    logic       m_ace    = 1'b0;
    logic       m_est    = 1'b0;

    function automatic int pick(input logic [2:0] req, input int ini);
        for (int k = 0; k < 3; k++)
            if (req[(ini + k) % 3]) return (ini + k) % 3;
        return -1;
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_owner = -1; m_wait = 0; m_ultimo = 2; m_ctrl = 2'd0; m_ace = 1'b0; m_est = 1'b0;
        end else begin
            m_ace = 1'b0;
            m_est = 1'b0;
            if (m_owner < 0) begin
                if (Pedido != 3'b000) begin
                    m_owner = pick(Pedido, RR ? (m_ultimo + 1) % 3 : 0);
                    m_wait  = 0;
                end
            end else if (Pronto) begin
                m_ace    = 1'b1;
                m_ultimo = m_owner;
                if (Pedido != 3'b000) begin
                    m_owner = pick(Pedido, RR ? (m_owner + 1) % 3 : 0);
                    m_wait  = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (!Pedido[m_owner]) begin
                m_owner = -1;
            end else begin
                m_wait++;
                if (m_wait == LIM) begin
                    m_est    = 1'b1;
                    m_ultimo = m_owner;
                    m_owner  = -1;
                end
            end
            if (m_owner >= 0) m_ctrl = 2'(m_owner);
        end
    end

    always @(negedge Clock) begin
        logic [2:0] econc;
        logic       eval;
        econc = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        eval  = (m_owner >= 0);
        n_tests++;
        if (Controle !== m_ctrl || Concessao !== econc || Valido !== eval ||
            Aceito !== m_ace || Estouro !== m_est) begin
            n_fail++;
            $display("FAIL model t=%0t got ctrl=%b conc=%b val=%b ace=%b est=%b want ctrl=%b conc=%b val=%b ace=%b est=%b",
                     $time, Controle, Concessao, Valido, Aceito, Estouro,
                     m_ctrl, econc, eval, m_ace, m_est);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Pedido = 3'b000; Pronto = 1'b0;
        edge1();
        Reset = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset_outs", 8'({Controle, Concessao, Valido, Aceito, Estouro}), 8'h00);
        edge1();
        Reset = 1'b0;

        Pedido = 3'b001; Pronto = 1'b1;
        edge1();
        chk("single_ctrl", 8'(Controle), 8'd0);
        chk("single_conc", 8'(Concessao), 8'b001);
        chk("single_val", 8'(Valido), 8'd1);
        Pedido = 3'b000;
        edge1();
        chk("single_ace", 8'(Aceito), 8'd1);
        chk("single_idle", 8'(Valido), 8'd0);
        edge1();
        chk("ace_pulse", 8'(Aceito), 8'd0);

        do_reset();
        Pedido = 3'b111; Pronto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edge1();
            chk("rr_ctrl", 8'(Controle), RR ? 8'(i % 3) : 8'd0);
            chk("rr_conc", 8'(Concessao), RR ? 8'(3'b001 << (i % 3)) : 8'b001);
            chk("rr_val", 8'(Valido), 8'd1);
            chk("rr_ace", 8'(Aceito), (i > 0) ? 8'd1 : 8'd0);
        end

        do_reset();
        Pedido = 3'b010; Pronto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("wd_val", 8'(Valido), 8'd1);
            chk("wd_est_low", 8'(Estouro), 8'd0);
        end
        Pedido = 3'b110;
        edge1();
        chk("wd_est", 8'(Estouro), 8'd1);
        chk("wd_conc", 8'(Concessao), 8'b000);
        chk("wd_val_off", 8'(Valido), 8'd0);
        edge1();
        chk("wd_next", 8'(Controle), RR ? 8'd2 : 8'd1);
        chk("wd_est_pulse", 8'(Estouro), 8'd0);

        do_reset();
        Pedido = 3'b010; Pronto = 1'b0;
        edge1();
        chk("ab_conc", 8'(Concessao), 8'b010);
        Pedido = 3'b000;
        edge1();
        chk("ab_flags", 8'({Valido, Aceito, Estouro}), 8'd0);

        do_reset();
        Pedido = 3'b001; Pronto = 1'b0;
        edge1();
        chk("ar_val", 8'(Valido), 8'd1);
        #2 Reset = 1'b1;
        #1;
        chk("ar_outs", 8'({Controle, Concessao, Valido, Aceito, Estouro}), 8'h00);
        edge1();
        Reset = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            edge1();
            Reset  = ($urandom_range(0, 399) == 0);
            Pedido = 3'($urandom_range(0, 7));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) Pedido[m_owner] = 1'b1;
            Pronto = ($urandom_range(0, 2) == 0);
        end
        Reset = 1'b0;
        edge1();
        edge1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
